mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single SDRAM read/write port between the display pixel-fetch path and the sprite/background loader. The display path owns the port by priority, and a starvation guard guarantees the loader forward progress. A small in-order owner FIFO routes each returned read word back to the requester that issued it. The block sits between the colour-mapping fetch logic and the SDRAM controller front end.

## Interface
- ADDR_W, 20, word address width (covers background at 0 and sprite sheet at 307201+)
- DATA_W, 32, data word width ([23:16] R, [15:8] G, [7:0] B)
- DEPTH, 4, max outstanding reads (owner FIFO depth, power of 2)
- STARVE_LIM, 8, consecutive display grants allowed while loader waits
- Clk  in  1  single clock; all state on rising edge
- Reset_n  in  1  synchronous, active-low reset
- disp_req  in  1  display read request; held with disp_addr until disp_gnt
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle (combinational)
- disp_rdata  out  DATA_W  returned display word
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse
- ld_req  in  1  loader request; held with ld_we/ld_addr/ld_wdata until ld_gnt
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_rdata  out  DATA_W  returned loader read word
- ld_rvalid  out  1  ld_rdata valid, one-cycle pulse
- mem_req  out  1  request to memory (combinational)
- mem_we  out  1  write strobe for mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rdata  in  DATA_W  read return data
- mem_rvalid  in  1  read return valid; returns are in issue order
- err_orphan  out  1  sticky: mem_rvalid arrived with owner FIFO empty

## Operation
- Eligibility:
  - A read request (display, or loader with ld_we=0) is eligible only when the owner FIFO count < DEPTH.
  - A loader write is always eligible.
- Selection each cycle:
  - If starve_cnt == STARVE_LIM and ld_req is eligible, select the loader.
  - Otherwise, if disp_req is eligible, select the display.
  - Otherwise, if ld_req is eligible, select the loader.
  - Otherwise select none.
- The selected request drives mem_req/mem_we/mem_addr/mem_wdata. With no selection, mem_req=0 and the other mem_* outputs are 0.
- Grant: the selected requester's gnt = mem_req & mem_ready. The non-selected gnt = 0. At most one gnt is high per cycle.
- Owner FIFO:
  - On a read grant, push owner (0 = display, 1 = loader).
  - On mem_rvalid with count > 0, pop the head.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - A push is never attempted when full, because eligibility blocks it. A pop that frees a slot in the same cycle does not make a read eligible that cycle.
- Return routing: on mem_rvalid, register mem_rdata into the head owner's rdata and assert that owner's rvalid for one cycle. The other requester's rvalid = 0 and its rdata holds its last value.
- Orphan return: mem_rvalid with count == 0 sets err_orphan. The data is dropped and neither rvalid asserts. err_orphan clears only on reset.
- starve_cnt (width clog2(STARVE_LIM+1)):
  - Increments on a display grant while ld_req=1.
  - Resets to 0 on any loader grant, or on any cycle with ld_req=0.
  - Saturates at STARVE_LIM.

## Timing
- Grant: combinational, same cycle as request and mem_ready.
- Read return latency through the block: 1 cycle (mem_rvalid in cycle N gives disp_rvalid/ld_rvalid in N+1).
- Reset (Reset_n=0 at a clock edge) takes effect at that edge:
  - FIFO emptied, count=0, starve_cnt=0.
  - disp_rvalid=ld_rvalid=0, disp_rdata=ld_rdata=0, err_orphan=0.
- While Reset_n=0, mem_req, disp_gnt and ld_gnt are forced to 0.
- Reset mid-operation: outstanding owner tags are discarded. A mem_rvalid arriving after reset with an empty FIFO sets err_orphan. The memory controller must be reset on the same Reset_n.
- Full back-pressure: with DEPTH reads outstanding, read requests wait and loader writes still proceed.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles with both reqs high and mem_ready=1 -> mem_req=0, both gnt=0, all rvalid=0, err_orphan=0. After release, disp_gnt=1 first.
- Priority and starvation: disp_req and ld_req (write, addr 0x4B001) held with mem_ready=1 -> 8 consecutive disp_gnt, then one ld_gnt with mem_we=1 and mem_addr=0x4B001, then display resumes.
- Routing: display reads addr 0x00000, loader reads 0x4B001, display reads 0x00001; memory returns 0xAA, 0xBB, 0xCC on 3 later mem_rvalid cycles -> disp 0xAA, ld 0xBB, disp 0xCC, each exactly 1 cycle after its mem_rvalid.
- Full: 4 display reads outstanding with no returns -> disp_gnt=0 and a loader write is still granted. One mem_rvalid -> disp_gnt=1 on the next cycle, not the same cycle.
- Simultaneous push/pop: a read grant and mem_rvalid in the same cycle at count=2 -> count stays 2 and ordering is preserved.
- Orphan: mem_rvalid with FIFO empty -> err_orphan=1 and sticky, no rvalid pulse. It clears only on Reset_n=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single SDRAM read/write port between the display pixel-fetch
// path and the sprite/background loader. The display path wins by priority.
// A starvation counter forces one loader grant after STARVE_LIM consecutive
// display grants while the loader waits. An in-order owner FIFO remembers
// who issued each read, so every returned word reaches its requester.
//
// Ports
//   Clk, Reset_n               clock, synchronous active-low reset
//   disp_req/addr              display read request (held until disp_gnt)
//   disp_gnt                   display request accepted (combinational)
//   disp_rdata/rvalid          registered display read return
//   ld_req/we/addr/wdata       loader read/write request (held until ld_gnt)
//   ld_gnt                     loader request accepted (combinational)
//   ld_rdata/rvalid            registered loader read return
//   mem_req/we/addr/wdata      request towards the SDRAM controller
//   mem_ready                  controller accepts mem_req this cycle
//   mem_rdata/rvalid           in-order read returns from the controller
//   err_orphan                 sticky flag: a return arrived with no owner
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              err_orphan
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  LIM_C   = SC_W'(STARVE_LIM);

    logic [DEPTH-1:0] ownerMem_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SC_W-1:0]  starveCnt_q;
    logic [SC_W-1:0]  starveCnt_d;

    logic [DATA_W-1:0] dispRdata_q;
    logic [DATA_W-1:0] ldRdata_q;
    logic              dispRvalid_q;
    logic              ldRvalid_q;
    logic              errOrphan_q;

    logic readOk;
    logic dispElig;
    logic ldElig;
    logic starved;
    logic selDisp;
    logic selLd;
    logic push;
    logic pop;
    logic headOwner;

    // Request selection. Eligibility uses the registered count only, so a
    // slot freed by a return this cycle becomes usable on the next cycle.
    always_comb begin
        readOk   = (count_q < DEPTH_C);
        dispElig = disp_req & readOk;
        ldElig   = ld_req & (ld_we | readOk);
        starved  = (starveCnt_q == LIM_C);
        selDisp  = 1'b0;
        selLd    = 1'b0;
        if (Reset_n) begin
            if (starved && ldElig) begin
                selLd = 1'b1;
            end else if (dispElig) begin
                selDisp = 1'b1;
            end else if (ldElig) begin
                selLd = 1'b1;
            end
        end
    end

    assign mem_req   = selDisp | selLd;
    assign mem_we    = selLd & ld_we;
    assign mem_addr  = selDisp ? disp_addr : (selLd ? ld_addr : '0);
    assign mem_wdata = selLd ? ld_wdata : '0;

    assign disp_gnt  = selDisp & mem_ready;
    assign ld_gnt    = selLd & mem_ready;

    // Only reads need an owner tag; loader writes produce no return.
    assign push      = disp_gnt | (ld_gnt & ~ld_we);
    assign pop       = mem_rvalid & (count_q != '0);
    assign headOwner = ownerMem_q[rdPtr_q];

    // Next-state for occupancy and starvation counter.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        starveCnt_d = starveCnt_q;
        if (ld_gnt || !ld_req) begin
            starveCnt_d = '0;
        end else if (disp_gnt && (starveCnt_q != LIM_C)) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    // Owner FIFO storage and pointers; tag 1 marks a loader read.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ownerMem_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            starveCnt_q <= '0;
        end else begin
            if (push) begin
                ownerMem_q[wrPtr_q] <= ld_gnt;
                wrPtr_q             <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q     <= count_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // Return routing: the head tag picks which requester sees the word.
    // The other side keeps its last data; a return with no owner is dropped
    // and latched as an orphan error.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            dispRdata_q  <= '0;
            ldRdata_q    <= '0;
            dispRvalid_q <= 1'b0;
            ldRvalid_q   <= 1'b0;
            errOrphan_q  <= 1'b0;
        end else begin
            dispRvalid_q <= pop & ~headOwner;
            ldRvalid_q   <= pop & headOwner;
            if (pop && !headOwner) begin
                dispRdata_q <= mem_rdata;
            end
            if (pop && headOwner) begin
                ldRdata_q <= mem_rdata;
            end
            if (mem_rvalid && (count_q == '0)) begin
                errOrphan_q <= 1'b1;
            end
        end
    end

    assign disp_rdata  = dispRdata_q;
    assign disp_rvalid = dispRvalid_q;
    assign ld_rdata    = ldRdata_q;
    assign ld_rvalid   = ldRvalid_q;
    assign err_orphan  = errOrphan_q;

endmodule
